gpio_bank_scheduler: RTL and testbench
======================================

Name: gpio_bank_scheduler

Overview:
Time-multiplexed controller for the banked fast-GPIO datapath, sitting between the host register interface and the NBANK output/input GPIO bank registers.
- Holds one shadow output word and one captured input word per bank.
- Round-robin scans the banks: drives each bank's shadow word to its output register, then samples its input register.
- Arbitrates host shadow/capture accesses into the scan.

Parameters:
WIDTH, 32, data width of each bank register
NBANK, 4, number of GPIO banks (2..16)
AW, 2, bank address width; AW >= clog2(NBANK)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous, active-low reset
scan_en  input  1  level; 1 = run continuous bank scan
host_req  input  1  host access request; held high until host_ack
host_we  input  1  1 = write shadow[host_addr], 0 = read capture[host_addr]
host_addr  input  AW  bank index
host_wdata  input  WIDTH  write data
host_ack  output  1  one-cycle completion pulse
host_rdata  output  WIDTH  read data, valid in ack cycle, held until next read ack
pin_sel  output  AW  bank currently addressed on pin bus
pin_wen  output  1  load output bank pin_sel with pin_wdata at this clock edge
pin_wdata  output  WIDTH  shadow[pin_sel]
pin_ren  output  1  input bank pin_sel is being sampled this cycle
pin_rdata  input  WIDTH  input-bank value for pin_sel, combinational, valid while pin_ren=1
scan_done  output  1  one-cycle pulse after bank NBANK-1 captured

Behaviour:
Reset (async, rstn=0):
- state=IDLE, bank=0, all shadow and capture words = 0.
- host_ack=0, host_rdata=0, pin_sel=0, pin_wen=0, pin_ren=0, pin_wdata=0, scan_done=0.
- A reset mid-operation aborts the current slot immediately. No ack is issued for an in-flight request.

State machine: IDLE, DRIVE, SAMPLE, HOST. All outputs are registered or decoded from registered state only.

IDLE:
- host_req=1 -> HOST.
- Else scan_en=1 -> DRIVE with current bank.
- host_req takes priority over scan start.

DRIVE (1 cycle):
- pin_sel=bank, pin_wen=1, pin_wdata=shadow[bank].
- Always -> SAMPLE.

SAMPLE (1 cycle):
- pin_sel=bank, pin_ren=1.
- capture[bank] <= pin_rdata at the closing edge.
- bank <= bank+1, wrapping NBANK-1 -> 0.
- On that wrap, scan_done=1 for the following cycle.
- Next state: host_req -> HOST; else scan_en -> DRIVE; else IDLE.

HOST (1 cycle):
- host_ack=1.
- On entry edge, host_rdata <= capture[host_addr] for reads; host_rdata unchanged for writes.
- Write: shadow[host_addr] <= host_wdata at the closing edge.
- Next state: scan_en -> DRIVE; else IDLE.
- A still-high host_req in the following cycle is a new request; the requester drops it after ack.

Arbitration and latency:
- At most one HOST slot between consecutive banks. The scan cannot starve, and the host waits at most 2 cycles: request seen during DRIVE gets ack 2 cycles later; from IDLE, ack the cycle after req is sampled.
- Scan throughput: 2 cycles per bank with no host traffic, 3 with.

Boundary conditions:
- host_addr >= NBANK: ack still given. Write ignored; read returns 0.
- Host write to bank k: seen on pins at the next DRIVE of bank k, never mid-slot.
- Host read of the bank just sampled: returns the new capture, since SAMPLE precedes HOST.
- scan_en deasserted during DRIVE: the SAMPLE of that bank still completes, then IDLE.
- bank is retained across IDLE; a resumed scan continues from the next bank, not bank 0.
- pin_wen and pin_ren are never both 1. pin_wen/pin_ren are 0 in IDLE and HOST.

Test Plan:
1. Reset, scan_en=0, write shadow[2]=0xA5A5_0F0F -> ack one cycle after req. All pin_* stay 0. After scan_en=1, pin_wen with pin_sel=2 shows pin_wdata=0xA5A5_0F0F.
2. scan_en=1, pin_rdata model returns 0x1000_0000+sel, NBANK=4 -> pin_sel sequence 0,0,1,1,2,2,3,3 with wen/ren alternating. scan_done pulses every 8 cycles. Host reads of banks 0..3 return 0x1000_0000..0x1000_0003.
3. Continuous host_req (toggled after each ack) during scan -> exactly one HOST slot per bank, 12-cycle scan period, every request acked within 2 cycles of presentation.
4. host_req asserted in the same cycle scan_en rises from IDLE -> HOST first, then DRIVE of bank 0.
5. rstn pulsed low during a HOST write of 0xFFFF_FFFF to bank 1 -> no ack. shadow[1] reads back 0 via the next scan DRIVE. bank restarts at 0.
6. host_addr=5 with NBANK=4 (AW=3): write acked with no shadow change; read acked with host_rdata=0.

Source files
------------

// File: rtl/gpio_bank_scheduler_if.sv
// Host register-access bus of the GPIO bank scheduler.
//   host_req   : request, held high by the host until host_ack
//   host_we    : 1 = write shadow[host_addr], 0 = read capture[host_addr]
//   host_addr  : bank index
//   host_wdata : shadow write data
//   host_ack   : one-cycle completion pulse
//   host_rdata : capture read data, valid in the ack cycle, held until next read ack
// master = host side, slave = scheduler side.
interface gpio_bank_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 2
);
  logic             host_req;
  logic             host_we;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic             host_ack;
  logic [WIDTH-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/gpio_bank_scheduler.sv
// Time-multiplexed controller for the banked fast-GPIO datapath.
// Keeps one shadow output word and one captured input word per bank and
// round-robin scans the banks (DRIVE the shadow word, then SAMPLE the input
// bank). Host accesses to shadow/capture are slotted in between banks, at
// most one HOST slot per bank, so neither the scan nor the host can starve.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   scan_en     : level, 1 = keep scanning
//   host        : host access bus (slave modport)
//   pin_sel     : bank addressed on the pin bus
//   pin_wen     : load output bank pin_sel with pin_wdata at this edge
//   pin_wdata   : shadow[pin_sel] during DRIVE
//   pin_ren     : input bank pin_sel sampled this cycle
//   pin_rdata   : combinational input-bank value for pin_sel
//   scan_done   : one-cycle pulse after bank NBANK-1 has been captured
module gpio_bank_scheduler #(
  parameter int WIDTH = 32,
  parameter int NBANK = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 scan_en,
  gpio_bank_scheduler_if.slave host,
  output logic [AW-1:0]        pin_sel,
  output logic                 pin_wen,
  output logic [WIDTH-1:0]     pin_wdata,
  output logic                 pin_ren,
  input  logic [WIDTH-1:0]     pin_rdata,
  output logic                 scan_done
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOST} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    bank_reg, bank_next;
  logic [WIDTH-1:0] shadow_reg  [NBANK];
  logic [WIDTH-1:0] capture_reg [NBANK];
  logic [WIDTH-1:0] host_rdata_reg, host_rdata_next;
  logic             scan_done_reg;

  logic [NBANK-1:0] addr_hit;
  logic [NBANK-1:0] bank_hit;
  logic             bank_wrap;
  logic [WIDTH-1:0] shadow_at_bank;
  logic [WIDTH-1:0] capture_at_addr;

  // One-hot decodes. An out-of-range host_addr hits no bank, which is what
  // makes such writes no-ops and such reads return 0.
  for (genvar gi = 0; gi < NBANK; gi++) begin : g_decode
    assign addr_hit[gi] = (host.host_addr == AW'(gi));
    assign bank_hit[gi] = (bank_reg == AW'(gi));
  end

  assign bank_wrap = (bank_reg == AW'(NBANK - 1));
  assign bank_next = bank_wrap ? '0 : bank_reg + AW'(1);

  always_comb begin
    shadow_at_bank  = '0;
    capture_at_addr = '0;
    for (int i = 0; i < NBANK; i++) begin
      if (bank_hit[i]) shadow_at_bank  = shadow_reg[i];
      if (addr_hit[i]) capture_at_addr = capture_reg[i];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // DRIVE and HOST never go to HOST, so a host slot only ever follows a
  // completed SAMPLE (or IDLE): at most one host slot between banks.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (host.host_req)  state_next = HOST;
        else if (scan_en)   state_next = DRIVE;
      end
      DRIVE:                state_next = SAMPLE;
      SAMPLE: begin
        if (host.host_req)  state_next = HOST;
        else if (scan_en)   state_next = DRIVE;
        else                state_next = IDLE;
      end
      HOST: begin
        if (scan_en)        state_next = DRIVE;
        else                state_next = IDLE;
      end
      default:              state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (decoded from registered state) ----------------
  always_comb begin
    pin_sel       = '0;
    pin_wen       = 1'b0;
    pin_ren       = 1'b0;
    pin_wdata     = '0;
    host.host_ack = 1'b0;
    case (state_reg)
      DRIVE: begin
        pin_sel   = bank_reg;
        pin_wen   = 1'b1;
        pin_wdata = shadow_at_bank;
      end
      SAMPLE: begin
        pin_sel = bank_reg;
        pin_ren = 1'b1;
      end
      HOST:    host.host_ack = 1'b1;
      default: ;
    endcase
  end

  assign host.host_rdata = host_rdata_reg;
  assign scan_done       = scan_done_reg;

  // Read data is latched on the edge entering HOST. When that edge also
  // closes the SAMPLE of the requested bank, the capture register is being
  // written at the same edge, so forward pin_rdata to return the new value.
  always_comb begin
    host_rdata_next = host_rdata_reg;
    if (state_next == HOST && !host.host_we) begin
      if (state_reg == SAMPLE && host.host_addr == bank_reg)
        host_rdata_next = pin_rdata;
      else
        host_rdata_next = capture_at_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_reg       <= '0;
      host_rdata_reg <= '0;
      scan_done_reg  <= 1'b0;
    end else begin
      host_rdata_reg <= host_rdata_next;
      scan_done_reg  <= (state_reg == SAMPLE) && bank_wrap;
      if (state_reg == SAMPLE) bank_reg <= bank_next;
    end
  end

  // Shadow words change only at the end of a HOST slot, so a DRIVE always
  // shows a whole word and a host write appears at the next DRIVE of that bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NBANK; i++) begin
        shadow_reg[i]  <= '0;
        capture_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (state_reg == SAMPLE && bank_hit[i])
          capture_reg[i] <= pin_rdata;
        if (state_reg == HOST && host.host_we && addr_hit[i])
          shadow_reg[i] <= host.host_wdata;
      end
    end
  end

endmodule

// File: tb/tb_gpio_bank_scheduler.sv
module tb_gpio_bank_scheduler;
  localparam int WIDTH = 32;
  localparam int NBANK = 4;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             scan_en = 1'b0;
  logic [AW-1:0]    pin_sel;
  logic             pin_wen, pin_ren, scan_done;
  logic [WIDTH-1:0] pin_wdata, pin_rdata;
  logic [WIDTH-1:0] rd_base = 32'h1000_0000;

  int total = 0;
  int bad   = 0;

  gpio_bank_scheduler_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  gpio_bank_scheduler #(.WIDTH(WIDTH), .NBANK(NBANK), .AW(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .scan_en   (scan_en),
    .host      (bus),
    .pin_sel   (pin_sel),
    .pin_wen   (pin_wen),
    .pin_wdata (pin_wdata),
    .pin_ren   (pin_ren),
    .pin_rdata (pin_rdata),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  // Input-bank model: each bank returns base + its index.
  assign pin_rdata = rd_base + WIDTH'(pin_sel);

  // ---------------- reference model ----------------
  // Shadow/capture contents, the bank the scan must visit next, and whether
  // a scan_done pulse is owed in the coming cycle.
  logic [WIDTH-1:0] shadow_m  [NBANK];
  logic [WIDTH-1:0] capture_m [NBANK];
  int  exp_bank;
  bit  done_pending;
  bit  mon_on = 1'b0;

  function automatic void model_clear();
    for (int i = 0; i < NBANK; i++) begin
      shadow_m[i]  = '0;
      capture_m[i] = '0;
    end
    exp_bank     = 0;
    done_pending = 1'b0;
  endfunction

  initial model_clear();
  always @(negedge rstn) model_clear();

  // Pin-bus monitor: bank order, drive data, mutual exclusion, scan_done.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (scan_done !== done_pending) begin
        bad++;
        $display("FAIL mon_scan_done: got %b want %b at %0t", scan_done, done_pending, $time);
      end
      done_pending = 1'b0;
      total++;
      if (pin_wen === 1'b1 && pin_ren === 1'b1) begin
        bad++;
        $display("FAIL mon_wen_ren_both: wen=%b ren=%b at %0t", pin_wen, pin_ren, $time);
      end
      if (pin_wen === 1'b1) begin
        total++;
        if (pin_sel !== AW'(exp_bank) || pin_wdata !== shadow_m[exp_bank]) begin
          bad++;
          $display("FAIL mon_drive: got sel=%0d data=%h want sel=%0d data=%h at %0t",
                   pin_sel, pin_wdata, exp_bank, shadow_m[exp_bank], $time);
        end
      end
      if (pin_ren === 1'b1) begin
        total++;
        if (pin_sel !== AW'(exp_bank)) begin
          bad++;
          $display("FAIL mon_sample: got sel=%0d want sel=%0d at %0t", pin_sel, exp_bank, $time);
        end
        capture_m[exp_bank] = rd_base + WIDTH'(exp_bank);
        if (exp_bank == NBANK - 1) done_pending = 1'b1;
        exp_bank = (exp_bank + 1) % NBANK;
      end
    end
  end

  // ---------------- drivers (no checking) ----------------
  // Issues one host access from a negedge, waits for ack, drops req in the
  // ack cycle and idles one more cycle. lat = cycles from req to ack, -1 on timeout.
  task automatic host_op(input bit we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] wd,
                         input int max_wait, output logic [WIDTH-1:0] rd, output int lat);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    lat = 0;
    rd  = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.host_ack !== 1'b1 && lat < max_wait);
    if (bus.host_ack === 1'b1) begin
      rd = bus.host_rdata;
      if (we && int'(addr) < NBANK) shadow_m[addr] = wd;
    end else begin
      lat = -1;
    end
    bus.host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    scan_en      = 1'b0;
    bus.host_req = 1'b0;
    #2 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_scan();
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    #2 rstn = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.host_ack, pin_wen, pin_ren, scan_done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: ack/wen/ren/done=%b want 0000", {bus.host_ack, pin_wen, pin_ren, scan_done});
    end
    total++;
    if (bus.host_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 0", bus.host_rdata);
    end
    total++;
    if (pin_sel !== '0 || pin_wdata !== '0) begin
      bad++;
      $display("FAIL reset_pins: sel=%0d wdata=%h want 0/0", pin_sel, pin_wdata);
    end
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
  endtask

  task automatic test_idle_write();
    logic [WIDTH-1:0] rd;
    int lat;
    bit found;
    host_op(1'b1, 3'd2, 32'hA5A5_0F0F, 4, rd, lat);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL idle_write_latency: got %0d want 1", lat);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (pin_wen !== 1'b0 || pin_ren !== 1'b0 || pin_sel !== '0 || pin_wdata !== '0) begin
        bad++;
        $display("FAIL idle_pins: wen=%b ren=%b sel=%0d wdata=%h want all 0", pin_wen, pin_ren, pin_sel, pin_wdata);
      end
    end
    scan_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (pin_wen === 1'b1 && pin_sel === 3'd2) found = 1'b1;
    end
    total++;
    if (!found || pin_wdata !== 32'hA5A5_0F0F) begin
      bad++;
      $display("FAIL idle_write_drive: found=%b wdata=%h want 1/a5a50f0f", found, pin_wdata);
    end
    stop_scan();
  endtask

  task automatic test_scan();
    logic [WIDTH-1:0] rd;
    int lat, last_done, n_done;
    logic [AW-1:0] exp_sel;
    do_reset();
    rd_base = 32'h1000_0000;
    scan_en = 1'b1;
    last_done = -1;
    n_done = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_sel = AW'((i / 2) % NBANK);
      total++;
      if (pin_sel !== exp_sel || pin_wen !== (i % 2 == 0) || pin_ren !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL scan_seq[%0d]: sel=%0d wen=%b ren=%b want sel=%0d wen=%b ren=%b",
                 i, pin_sel, pin_wen, pin_ren, exp_sel, (i % 2 == 0), (i % 2 == 1));
      end
      if (scan_done === 1'b1) begin
        if (last_done >= 0) begin
          total++;
          if (i - last_done != 2 * NBANK) begin
            bad++;
            $display("FAIL scan_period: got %0d want %0d", i - last_done, 2 * NBANK);
          end
        end
        last_done = i;
        n_done++;
      end
    end
    total++;
    if (n_done != 2) begin
      bad++;
      $display("FAIL scan_done_count: got %0d want 2", n_done);
    end
    for (int k = 0; k < NBANK; k++) begin
      host_op(1'b0, AW'(k), '0, 4, rd, lat);
      total++;
      if (rd !== 32'h1000_0000 + WIDTH'(k) || lat < 1 || lat > 2) begin
        bad++;
        $display("FAIL scan_read[%0d]: got %h lat=%0d want %h lat<=2", k, rd, lat, 32'h1000_0000 + WIDTH'(k));
      end
    end
    stop_scan();
    rd_base = $urandom;
    scan_en = 1'b1;
    repeat (10) @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      int k;
      k = $urandom_range(0, NBANK - 1);
      host_op(1'b0, AW'(k), '0, 4, rd, lat);
      total++;
      if (rd !== rd_base + WIDTH'(k) || lat < 1 || lat > 2) begin
        bad++;
        $display("FAIL rand_read[%0d]: got %h lat=%0d want %h lat<=2", k, rd, lat, rd_base + WIDTH'(k));
      end
    end
    stop_scan();
  endtask

  task automatic test_back_to_back();
    bit pending, synced;
    int pend_lat, last_done, acks_since;
    logic [WIDTH-1:0] exp_rd;
    scan_en = 1'b1;
    synced = 1'b0;
    for (int c = 0; c < 20 && !synced; c++) begin
      @(negedge clk);
      if (scan_done === 1'b1) synced = 1'b1;
    end
    total++;
    if (!synced) begin
      bad++;
      $display("FAIL b2b_sync: no scan_done within 20 cycles");
    end
    pending = 1'b0; pend_lat = 0; last_done = -1; acks_since = 0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0 && scan_done === 1'b1) begin
        if (last_done >= 0) begin
          total++;
          if (c - last_done != 3 * NBANK || acks_since != NBANK) begin
            bad++;
            $display("FAIL b2b_period: period=%0d acks=%0d want %0d/%0d", c - last_done, acks_since, 3 * NBANK, NBANK);
          end
        end
        last_done = c;
        acks_since = 0;
      end
      if (pending) begin
        pend_lat++;
        if (bus.host_ack === 1'b1) begin
          total++;
          if (pend_lat > 2) begin
            bad++;
            $display("FAIL b2b_latency: got %0d want <=2", pend_lat);
          end
          if (!bus.host_we) begin
            exp_rd = (int'(bus.host_addr) < NBANK) ? capture_m[bus.host_addr] : '0;
            total++;
            if (bus.host_rdata !== exp_rd) begin
              bad++;
              $display("FAIL b2b_read[%0d]: got %h want %h", bus.host_addr, bus.host_rdata, exp_rd);
            end
          end else if (int'(bus.host_addr) < NBANK) begin
            shadow_m[bus.host_addr] = bus.host_wdata;
          end
          bus.host_req = 1'b0;
          pending = 1'b0;
          acks_since++;
        end else if (pend_lat > 4) begin
          total++; bad++;
          $display("FAIL b2b_timeout: no ack after %0d cycles", pend_lat);
          bus.host_req = 1'b0;
          pending = 1'b0;
        end
      end else begin
        bus.host_we    = $urandom_range(0, 1);
        bus.host_addr  = AW'($urandom_range(0, 7));
        bus.host_wdata = $urandom;
        bus.host_req   = 1'b1;
        pending  = 1'b1;
        pend_lat = 0;
      end
    end
    if (pending) begin
      for (int c = 0; c < 4 && bus.host_ack !== 1'b1; c++) @(negedge clk);
      if (bus.host_ack === 1'b1 && bus.host_we && int'(bus.host_addr) < NBANK)
        shadow_m[bus.host_addr] = bus.host_wdata;
      bus.host_req = 1'b0;
    end
    stop_scan();
  endtask

  task automatic test_req_with_scan_start();
    do_reset();
    scan_en = 1'b1;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = '0;
    @(negedge clk);
    total++;
    if (bus.host_ack !== 1'b1 || pin_wen !== 1'b0 || bus.host_rdata !== '0) begin
      bad++;
      $display("FAIL start_host_first: ack=%b wen=%b rdata=%h want 1/0/0", bus.host_ack, pin_wen, bus.host_rdata);
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    total++;
    if (pin_wen !== 1'b1 || pin_sel !== '0 || bus.host_ack !== 1'b0) begin
      bad++;
      $display("FAIL start_drive0: wen=%b sel=%0d ack=%b want 1/0/0", pin_wen, pin_sel, bus.host_ack);
    end
    stop_scan();
  endtask

  task automatic test_stop_in_drive();
    int b0;
    b0 = exp_bank;
    scan_en = 1'b1;
    @(negedge clk);
    total++;
    if (pin_wen !== 1'b1 || pin_sel !== AW'(b0)) begin
      bad++;
      $display("FAIL stop_first_drive: wen=%b sel=%0d want 1/%0d", pin_wen, pin_sel, b0);
    end
    scan_en = 1'b0;
    @(negedge clk);
    total++;
    if (pin_ren !== 1'b1 || pin_sel !== AW'(b0)) begin
      bad++;
      $display("FAIL stop_sample_completes: ren=%b sel=%0d want 1/%0d", pin_ren, pin_sel, b0);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (pin_wen !== 1'b0 || pin_ren !== 1'b0) begin
        bad++;
        $display("FAIL stop_idle: wen=%b ren=%b want 0/0", pin_wen, pin_ren);
      end
    end
    scan_en = 1'b1;
    @(negedge clk);
    total++;
    if (pin_wen !== 1'b1 || pin_sel !== AW'((b0 + 1) % NBANK)) begin
      bad++;
      $display("FAIL resume_next_bank: wen=%b sel=%0d want 1/%0d", pin_wen, pin_sel, (b0 + 1) % NBANK);
    end
    stop_scan();
  endtask

  task automatic test_reset_mid_host();
    logic [WIDTH-1:0] rd;
    int lat;
    rd_base = 32'hCAFE_0000;
    scan_en = 1'b1;
    repeat (10) @(negedge clk);
    stop_scan();
    host_op(1'b0, 3'd2, '0, 4, rd, lat);
    total++;
    if (rd !== 32'hCAFE_0002) begin
      bad++;
      $display("FAIL pre_reset_read: got %h want cafe0002", rd);
    end
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 3'd1; bus.host_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    total++;
    if (bus.host_ack !== 1'b0 || bus.host_rdata !== '0 || scan_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: ack=%b rdata=%h done=%b want 0/0/0", bus.host_ack, bus.host_rdata, scan_done);
    end
    bus.host_req = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    scan_en = 1'b1;
    @(negedge clk);
    total++;
    if (pin_wen !== 1'b1 || pin_sel !== 3'd0 || pin_wdata !== '0) begin
      bad++;
      $display("FAIL reset_restart_bank0: wen=%b sel=%0d wdata=%h want 1/0/0", pin_wen, pin_sel, pin_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (pin_wen !== 1'b1 || pin_sel !== 3'd1 || pin_wdata !== '0) begin
      bad++;
      $display("FAIL reset_shadow1_clear: wen=%b sel=%0d wdata=%h want 1/1/0", pin_wen, pin_sel, pin_wdata);
    end
    stop_scan();
  endtask

  task automatic test_out_of_range();
    logic [WIDTH-1:0] rd, x;
    int lat;
    bit found;
    x = $urandom | 32'h1;
    host_op(1'b1, 3'd1, x, 4, rd, lat);
    host_op(1'b1, 3'd5, ~x, 4, rd, lat);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL oor_write_ack: lat=%0d want 1", lat);
    end
    host_op(1'b0, 3'd0, '0, 4, rd, lat);
    total++;
    if (rd !== capture_m[0] || rd === '0) begin
      bad++;
      $display("FAIL oor_pre_read: got %h want %h (nonzero)", rd, capture_m[0]);
    end
    for (int a = 5; a <= 6; a++) begin
      host_op(1'b0, AW'(a), '0, 4, rd, lat);
      total++;
      if (lat != 1 || rd !== '0) begin
        bad++;
        $display("FAIL oor_read[%0d]: lat=%0d rdata=%h want 1/0", a, lat, rd);
      end
    end
    scan_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (pin_wen === 1'b1 && pin_sel === 3'd1) found = 1'b1;
    end
    total++;
    if (!found || pin_wdata !== x) begin
      bad++;
      $display("FAIL oor_no_alias: found=%b wdata=%h want 1/%h", found, pin_wdata, x);
    end
    stop_scan();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_write();
    test_scan();
    test_back_to_back();
    test_req_with_scan_start();
    test_stop_in_drive();
    test_reset_mid_host();
    test_out_of_range();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
